// File: rtl/polytris_pkg.sv
// Shared playfield constants, row type and line-clear FSM encoding.
package polytris_pkg;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(ROWS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } lc_state_t;

    typedef logic [COLS-1:0] row_t;

endpackage

// File: rtl/line_clear_ctrl_if.sv
// Game-FSM handshake plus playfield RAM read/write ports of the line-clear block.
// total_lines exists only when LINE_CLEAR_STATS_EN is defined.
interface line_clear_ctrl_if;
    import polytris_pkg::*;

    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] lines_cleared;
    logic          mem_rd_en;
    logic [RW-1:0] mem_rd_addr;
    row_t          mem_rd_data;
    logic          mem_wr_en;
    logic [RW-1:0] mem_wr_addr;
    row_t          mem_wr_data;

`ifdef LINE_CLEAR_STATS_EN
    logic [15:0]   total_lines;

    modport master (
        input  start, mem_rd_data,
        output busy, done, lines_cleared, mem_rd_en, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_data, total_lines
    );
    modport slave (
        output start, mem_rd_data,
        input  busy, done, lines_cleared, mem_rd_en, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_data, total_lines
    );
`else
    modport master (
        input  start, mem_rd_data,
        output busy, done, lines_cleared, mem_rd_en, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_data
    );
    modport slave (
        output start, mem_rd_data,
        input  busy, done, lines_cleared, mem_rd_en, mem_rd_addr,
               mem_wr_en, mem_wr_addr, mem_wr_data
    );
`endif

endinterface

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans rows bottom-up, compacts survivors downward, zero-fills the top.
// Latency 2*ROWS+k+1 cycles start->done; no backpressure, start ignored while busy. Option: LINE_CLEAR_STATS_EN.
module line_clear_ctrl
    import polytris_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    line_clear_ctrl_if.master bus
);

    localparam logic signed [RW:0] LAST_ROW = (RW+1)'(ROWS - 1);
    localparam logic signed [RW:0] PTR_ONE  = (RW+1)'(1);

    lc_state_t          state, state_nxt;
    logic signed [RW:0] rd_row, rd_nxt;
    logic signed [RW:0] wr_row, wr_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               full;

    assign full = &bus.mem_rd_data;

    always_comb begin
        state_nxt       = state;
        rd_nxt          = rd_row;
        wr_nxt          = wr_row;
        cnt_nxt         = cnt;
        bus.busy        = (state != IDLE);
        bus.done        = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    rd_nxt    = LAST_ROW;
                    wr_nxt    = LAST_ROW;
                    cnt_nxt   = '0;
                    state_nxt = READ;
                end
            end
            READ: begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = rd_row[RW-1:0];
                state_nxt       = CHECK;
            end
            CHECK: begin
                // wr_row never drops below rd_row here, so it is a valid address
                if (full) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    if (wr_row != rd_row) begin
                        bus.mem_wr_en   = 1'b1;
                        bus.mem_wr_addr = wr_row[RW-1:0];
                        bus.mem_wr_data = bus.mem_rd_data;
                    end
                    wr_nxt = wr_row - PTR_ONE;
                end
                if (rd_row == '0) begin
                    state_nxt = wr_nxt[RW] ? DONE : FILL;
                end else begin
                    rd_nxt    = rd_row - PTR_ONE;
                    state_nxt = READ;
                end
            end
            FILL: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = wr_row[RW-1:0];
                wr_nxt          = wr_row - PTR_ONE;
                if (wr_row == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            rd_row            <= '0;
            wr_row            <= '0;
            cnt               <= '0;
            bus.lines_cleared <= '0;
        end else begin
            state  <= state_nxt;
            rd_row <= rd_nxt;
            wr_row <= wr_nxt;
            cnt    <= cnt_nxt;
            // publish on entry to DONE so the result is visible alongside the done pulse
            if (state_nxt == DONE) begin
                bus.lines_cleared <= cnt_nxt;
            end
        end
    end

`ifdef LINE_CLEAR_STATS_EN
    logic [16:0] total_sum;

    assign total_sum = {1'b0, bus.total_lines} + {{(17-CW){1'b0}}, bus.lines_cleared};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.total_lines <= '0;
        end else if (state == DONE) begin
            bus.total_lines <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end
`endif

endmodule
